// File: rtl/mem_block_mover.sv
// mem_block_mover: copy or fill engine that drives a single-pointer data memory port
module mem_block_mover #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Length,
  input  logic [DW-1:0] FillVal,
  output logic [AW-1:0] MemAddr,
  output logic          MemWe,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] Count
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, DONE} state_t;
  state_t state;
  logic [AW-1:0] src, dst, rem;
  logic [DW-1:0] fill;
  // Outputs are loaded with the values for the state being entered, so every port is a flop
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      rem      <= '0;
      fill     <= '0;
      MemAddr  <= '0;
      MemWe    <= 1'b0;
      MemWData <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Count    <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          src   <= SrcAddr;
          dst   <= DstAddr;
          rem   <= Length;
          fill  <= FillVal;
          Count <= '0;
          Busy  <= 1'b1;
          if (Length == '0) begin
            state <= DONE;
            Done  <= 1'b1;
          end else if (Mode) begin
            state    <= FILL;
            MemAddr  <= DstAddr;
            MemWe    <= 1'b1;
            MemWData <= FillVal;
          end else begin
            state   <= READ;
            MemAddr <= SrcAddr;
          end
        end
        READ: begin
          state    <= WRITE;
          MemAddr  <= dst;
          MemWe    <= 1'b1;
          MemWData <= MemRData;
        end
        WRITE: begin
          src   <= src + 1'b1;
          dst   <= dst + 1'b1;
          rem   <= rem - 1'b1;
          Count <= Count + 1'b1;
          MemWe <= 1'b0;
          if (rem == AW'(1)) begin
            state   <= DONE;
            MemAddr <= '0;
            Done    <= 1'b1;
          end else begin
            state   <= READ;
            MemAddr <= src + 1'b1;
          end
        end
        FILL: begin
          dst   <= dst + 1'b1;
          rem   <= rem - 1'b1;
          Count <= Count + 1'b1;
          if (rem == AW'(1)) begin
            state   <= DONE;
            MemAddr <= '0;
            MemWe   <= 1'b0;
            Done    <= 1'b1;
          end else begin
            MemAddr  <= dst + 1'b1;
            MemWData <= fill;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: scoreboard bench with a 256x8 memory model behind the mover
module tb_mem_block_mover;
  logic       Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Mode = 1'b0;
  logic [7:0] SrcAddr = '0, DstAddr = '0, Length = '0, FillVal = '0;
  logic [7:0] MemAddr, MemWData, MemRData, Count;
  logic       MemWe, Busy, Done;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0, ld_data = '0;
  logic [7:0] src4 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [15:0] exp_q [$];
  int vectors = 0, miscompares = 0, done_cnt = 0, we_cnt = 0;

  mem_block_mover #(.AW(8), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .SrcAddr(SrcAddr),
    .DstAddr(DstAddr), .Length(Length), .FillVal(FillVal), .MemAddr(MemAddr),
    .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData), .Busy(Busy),
    .Done(Done), .Count(Count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (MemWe) mem[MemAddr] <= MemWData;
  end
  assign MemRData = mem[MemAddr];

  // Every cycle advance goes through here so each DUT write is scored against the queue
  task automatic tick();
    logic [15:0] e;
    @(negedge Clk);
    if (Done) done_cnt++;
    if (MemWe) begin
      we_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write", MemAddr, MemWData);
      end else begin
        e = exp_q.pop_front();
        if ({MemAddr, MemWData} !== e) begin
          miscompares++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", MemAddr, MemWData, e[15:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic start_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f, input int nexp);
    for (int i = 0; i < nexp; i++) begin
      logic [7:0] a, v;
      a = d + 8'(i);
      v = m ? f : exp_mem[s + 8'(i)];
      exp_q.push_back({a, v});
      exp_mem[a] = v;
    end
    tick();
    Mode = m; SrcAddr = s; DstAddr = d; Length = l; FillVal = f; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int first, input int limit, output int cyc);
    cyc = first;
    while (!Done && cyc < limit) begin
      tick();
      cyc++;
    end
    if (!Done) cyc = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge Clk);
      ld_en = 1'b1;
      ld_addr = 8'(i);
      ld_data = (i >= 16 && i < 20) ? src4[i-16] : (8'(i) ^ 8'h5C);
      exp_mem[i] = ld_data;
    end
    @(negedge Clk);
    ld_en = 1'b0;
    vectors++;
    if ({MemAddr, MemWe, MemWData, Busy, Done, Count} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got addr=%h we=%b wd=%h busy=%b done=%b cnt=%h, required all 0",
               MemAddr, MemWe, MemWData, Busy, Done, Count);
    end
    Reset = 1'b0;
  endtask

  task automatic test_copy();
    int c, d0;
    d0 = done_cnt;
    start_op(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 4);
    wait_done(1, 40, c);
    vectors++;
    if (c !== 9) begin miscompares++; $display("FAIL copy_done_cycle: got %0d, required 9", c); end
    vectors++;
    if (Count !== 8'd4) begin miscompares++; $display("FAIL copy_count: got %0d, required 4", Count); end
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[8'h40 + 8'(i)] !== src4[i]) begin
        miscompares++;
        $display("FAIL copy_mem[%0d]: got %h, required %h", i, mem[8'h40 + 8'(i)], src4[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL copy_pulses: got done=%0d pending=%0d, required done=1 pending=0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_fill();
    int c, w0;
    w0 = we_cnt;
    start_op(1'b1, 8'h00, 8'h80, 8'd3, 8'h5A, 3);
    wait_done(1, 40, c);
    vectors++;
    if (c !== 4) begin miscompares++; $display("FAIL fill_done_cycle: got %0d, required 4", c); end
    vectors++;
    if (we_cnt - w0 !== 3) begin miscompares++; $display("FAIL fill_we_cycles: got %0d, required 3", we_cnt - w0); end
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem[8'h80 + 8'(i)] !== 8'h5A) begin
        miscompares++;
        $display("FAIL fill_mem[%0d]: got %h, required 5a", i, mem[8'h80 + 8'(i)]);
      end
    end
  endtask

  task automatic test_wrap();
    int c;
    start_op(1'b1, 8'h00, 8'hFE, 8'd4, 8'h33, 4);
    wait_done(1, 40, c);
    tick();
    vectors++;
    if (c !== 5 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_done: got cycle=%0d pending=%0d, required cycle=5 pending=0", c, exp_q.size());
    end
    vectors++;
    if (mem[1] !== 8'h33 || mem[2] !== 8'h5E) begin
      miscompares++;
      $display("FAIL wrap_mem: got m1=%h m2=%h, required m1=33 m2=5e", mem[1], mem[2]);
    end
  endtask

  task automatic test_zero_len();
    int c, w0;
    w0 = we_cnt;
    start_op(1'b1, 8'h00, 8'h20, 8'd0, 8'hFF, 0);
    wait_done(1, 10, c);
    vectors++;
    if (c !== 1 || Count !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_len: got cycle=%0d count=%0d, required cycle=1 count=0", c, Count);
    end
    tick();
    tick();
    vectors++;
    if (we_cnt !== w0) begin miscompares++; $display("FAIL zero_len_we: got %0d writes, required 0", we_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    int c, d0;
    d0 = done_cnt;
    start_op(1'b0, 8'h10, 8'h60, 8'd5, 8'h00, 5);
    repeat (3) tick();
    Mode = 1'b1; DstAddr = 8'h10; Length = 8'd9; FillVal = 8'hEE; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(5, 40, c);
    vectors++;
    if (c !== 11 || Count !== 8'd5) begin
      miscompares++;
      $display("FAIL busy_start: got cycle=%0d count=%0d, required cycle=11 count=5", c, Count);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (Busy !== 1'b0 || Count !== 8'd5 || done_cnt - d0 !== 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL busy_after: got busy=%b count=%0d done=%0d pending=%0d, required 0/5/1/0",
               Busy, Count, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    start_op(1'b0, 8'h10, 8'hA0, 8'd6, 8'h00, 3);
    repeat (5) tick();
    vectors++;
    if (MemWe !== 1'b1 || MemAddr !== 8'hA2) begin
      miscompares++;
      $display("FAIL mid_third_write: got we=%b addr=%h, required we=1 addr=a2", MemWe, MemAddr);
    end
    Reset = 1'b1;
    tick();
    vectors++;
    if (MemWe !== 1'b0 || Busy !== 1'b0 || Count !== 8'd0 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got we=%b busy=%b count=%0d done=%b, required 0/0/0/0", MemWe, Busy, Count, Done);
    end
    Reset = 1'b0;
    repeat (10) tick();
    vectors++;
    if (done_cnt !== d0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_after: got done=%0d pending=%0d, required done=0 pending=0", done_cnt - d0, exp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem[8'hA0 + 8'(i)] !== src4[i]) begin
        miscompares++;
        $display("FAIL mid_mem[%0d]: got %h, required %h", i, mem[8'hA0 + 8'(i)], src4[i]);
      end
    end
  endtask

  task automatic test_memory_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL memory_image: got %0d differing bytes, required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    test_memory_image();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
